// File: rtl/lfsr_game_pkg.sv
// Shared definitions for the LFSR share arbiter slice.
// Contents:
//   LFSR_W        LFSR width (16)
//   LFSR_TAPS     Galois tap mask, bits {2,3,5} of x^16+x^5+x^3+x^2+1
//   DEFAULT_SEED  seed used whenever a zero seed is requested
//   arb_state_t   arbiter FSM states
//   player_t      player index (two players)
//   seed_fix()    maps a zero seed onto DEFAULT_SEED (zero would lock the LFSR)
package lfsr_game_pkg;

    localparam int          LFSR_W       = 16;
    localparam logic [15:0] LFSR_TAPS    = 16'h002C;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STEP    = 2'd1,
        DELIVER = 2'd2
    } arb_state_t;

    typedef logic player_t;

    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? DEFAULT_SEED : s;
    endfunction

endpackage

// File: rtl/lfsr_share_arbiter_if.sv
// Request/acknowledge bundle between the per-player game FSMs and the
// shared random-symbol arbiter.
//   Req   [1:0]      per-player level request (master -> slave)
//   Ack   [1:0]      one-cycle acknowledge, one-hot or zero (slave -> master)
//   Sym   [SYM_W-1:0] delivered symbol, held until the next delivery
//   Busy             arbiter not idle
//   Owner            player currently granted or last served
// Modports: master = game side, slave = arbiter side.
interface lfsr_share_arbiter_if #(
    parameter int SYM_W = 2
);
    logic [1:0]       Req;
    logic [1:0]       Ack;
    logic [SYM_W-1:0] Sym;
    logic             Busy;
    logic             Owner;

    modport master (output Req, input Ack, Sym, Busy, Owner);
    modport slave  (input Req, output Ack, Sym, Busy, Owner);
endinterface

// File: rtl/lfsr16_step.sv
// Enabled 16-bit Galois LFSR, polynomial x^16+x^5+x^3+x^2+1, feedback = q[15].
// Ports:
//   Clk       clock, rising edge
//   Rst       asynchronous active-high reset, loads SEED
//   step      advance one step this cycle
//   load      load load_val (zero maps to DEFAULT_SEED)
//   load_val  value to load
//   q         current state
// An all-zero state is a lockup; it reloads SEED on the next clock.
module lfsr16_step
    import lfsr_game_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        step,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] q
);
    localparam logic [15:0] SEED_EFF = seed_fix(SEED);

    logic        fb;
    logic [15:0] q_next;

    // Shift up, feed bit15 into bit0 and XOR it into the tap positions.
    assign fb     = q[15];
    assign q_next = {q[14:0], fb} ^ ({16{fb}} & LFSR_TAPS);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            q <= SEED_EFF;
        end else if (load) begin
            q <= seed_fix(load_val);
        end else if (q == 16'h0000) begin
            q <= SEED_EFF;
        end else if (step) begin
            q <= q_next;
        end
    end
endmodule

// File: rtl/lfsr_share_arbiter.sv
// Round-robin arbiter sharing one 16-bit Galois LFSR between two players.
// Each granted request advances the LFSR STEPS times, then delivers the low
// SYM_W bits with a one-cycle Ack to the owner.
// Ports:
//   bus       lfsr_share_arbiter_if.slave (Req, Ack, Sym, Busy, Owner)
//   Clk       clock, rising edge
//   Rst       asynchronous active-high reset
//   SeedLoad  (LFSR_SEED_LOAD_EN only) load SeedIn when idle
//   SeedIn    (LFSR_SEED_LOAD_EN only) 16-bit seed, zero maps to 16'hFFFF
// Optional feature macro: LFSR_SEED_LOAD_EN.
module lfsr_share_arbiter
    import lfsr_game_pkg::*;
#(
    parameter int          SYM_W = 2,
    parameter int          STEPS = 4,
    parameter logic [15:0] SEED  = 16'hFFFF
) (
    lfsr_share_arbiter_if.slave bus,
    input  logic                Clk,
    input  logic                Rst
`ifdef LFSR_SEED_LOAD_EN
    ,
    input  logic                SeedLoad,
    input  logic [15:0]         SeedIn
`endif
);
    arb_state_t  state;
    logic [3:0]  cnt;
    player_t     ptr;        // last-served player; the other one wins a tie
    player_t     winner;
    logic        step;
    logic        load;
    logic [15:0] load_val;
    logic [15:0] lfsr_q;

    assign step = (state == STEP);

`ifdef LFSR_SEED_LOAD_EN
    assign load     = (state == IDLE) && SeedLoad;
    assign load_val = SeedIn;
`else
    assign load     = 1'b0;
    assign load_val = 16'h0000;
`endif

    always_comb begin
        winner = player_t'(bus.Req[1]);
        if (bus.Req == 2'b11) begin
            winner = ~ptr;
        end
    end

    lfsr16_step #(
        .SEED (SEED)
    ) u_lfsr (
        .Clk      (Clk),
        .Rst      (Rst),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .q        (lfsr_q)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            ptr       <= 1'b1;
            bus.Ack   <= 2'b00;
            bus.Sym   <= '0;
            bus.Busy  <= 1'b0;
            bus.Owner <= 1'b0;
        end else begin
            bus.Ack <= 2'b00;
            case (state)
                IDLE: begin
                    // A seed load takes the whole idle cycle; requests wait.
                    if (load) begin
                        ptr <= 1'b1;
                    end else if (bus.Req != 2'b00) begin
                        bus.Owner <= winner;
                        cnt       <= 4'(STEPS);
                        state     <= STEP;
                        bus.Busy  <= 1'b1;
                    end
                end
                STEP: begin
                    cnt <= cnt - 4'd1;
                    // Only the last step cycle decides whether the owner still wants it.
                    if (cnt == 4'd1) begin
                        if (bus.Req[bus.Owner]) begin
                            state <= DELIVER;
                        end else begin
                            state    <= IDLE;
                            bus.Busy <= 1'b0;
                        end
                    end
                end
                DELIVER: begin
                    bus.Ack  <= bus.Owner ? 2'b10 : 2'b01;
                    bus.Sym  <= lfsr_q[SYM_W-1:0];
                    ptr      <= bus.Owner;
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lfsr_share_arbiter.sv
// Directed testbench for lfsr_share_arbiter. Two instances share clock and
// reset: dut1 (STEPS=1, SYM_W=2) and dut4 (STEPS=4, SYM_W=16, full state
// visible on Sym). Seed-load scenario only with LFSR_SEED_LOAD_EN.
// LFSR states from 16'hFFFF: s1=FFD3 s4=FE5B s8=E41B s12=4036 s16=03D4.
module tb_lfsr_share_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic        SeedLoad = 1'b0;
    logic [15:0] SeedIn = 16'h0000;
    logic        sl1 = 1'b0;
    logic [15:0] si1 = 16'h0000;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    lfsr_share_arbiter_if #(.SYM_W(2))  bus1 ();
    lfsr_share_arbiter_if #(.SYM_W(16)) bus4 ();

    lfsr_share_arbiter #(.SYM_W(2), .STEPS(1), .SEED(16'hFFFF)) dut1 (
        .bus      (bus1),
        .Clk      (Clk),
        .Rst      (Rst)
`ifdef LFSR_SEED_LOAD_EN
        ,
        .SeedLoad (sl1),
        .SeedIn   (si1)
`endif
    );

    lfsr_share_arbiter #(.SYM_W(16), .STEPS(4), .SEED(16'hFFFF)) dut4 (
        .bus      (bus4),
        .Clk      (Clk),
        .Rst      (Rst)
`ifdef LFSR_SEED_LOAD_EN
        ,
        .SeedLoad (SeedLoad),
        .SeedIn   (SeedIn)
`endif
    );

    // Reference LFSR: x^16+x^5+x^3+x^2+1, Galois, feedback bit15.
    function automatic logic [15:0] adv(input logic [15:0] s, input int n);
        logic [15:0] r;
        logic        fb;
        r = s;
        for (int i = 0; i < n; i++) begin
            fb   = r[15];
            r    = {r[14:0], 1'b0};
            r[0] = fb;
            r[2] = r[2] ^ fb;
            r[3] = r[3] ^ fb;
            r[5] = r[5] ^ fb;
        end
        return r;
    endfunction

    task automatic do_reset();
        Rst      = 1'b1;
        bus1.Req = 2'b00;
        bus4.Req = 2'b00;
        SeedLoad = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic wait_ack4(input int limit, output int cycles, output logic [1:0] ack);
        cycles = 0;
        ack    = 2'b00;
        while (cycles < limit && ack == 2'b00) begin
            @(negedge Clk);
            cycles++;
            ack = bus4.Ack;
        end
    endtask

    task automatic run_one(output logic [15:0] sym, output logic [1:0] ack);
        int c;
        bus4.Req = 2'b01;
        wait_ack4(20, c, ack);
        sym      = bus4.Sym;
        bus4.Req = 2'b00;
    endtask

    task automatic test_reset();
        bus1.Req = 2'b00;
        bus4.Req = 2'b00;
        #1 Rst = 1'b1;
        #1;
        checks++; if (bus4.Ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", bus4.Ack); end
        checks++; if (bus4.Sym !== 16'h0000) begin failures++; $display("FAIL reset_sym got=%h exp=0000", bus4.Sym); end
        checks++; if (bus4.Busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus4.Busy); end
        checks++; if (bus4.Owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%b exp=0", bus4.Owner); end
        checks++; if (dut4.u_lfsr.q !== 16'hFFFF) begin failures++; $display("FAIL reset_lfsr got=%h exp=FFFF", dut4.u_lfsr.q); end
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    task automatic test_basic_steps1();
        do_reset();
        bus1.Req = 2'b01;
        @(posedge Clk);
        @(negedge Clk);
        checks++; if (bus1.Busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bus1.Busy); end
        checks++; if (bus1.Ack !== 2'b00) begin failures++; $display("FAIL basic_early_ack got=%b exp=00", bus1.Ack); end
        @(negedge Clk);
        checks++; if (dut1.u_lfsr.q !== 16'hFFD3) begin failures++; $display("FAIL basic_lfsr got=%h exp=FFD3", dut1.u_lfsr.q); end
        checks++; if (bus1.Ack !== 2'b00) begin failures++; $display("FAIL basic_deliver_ack got=%b exp=00", bus1.Ack); end
        @(negedge Clk);
        checks++; if (bus1.Ack !== 2'b01) begin failures++; $display("FAIL basic_ack got=%b exp=01", bus1.Ack); end
        checks++; if (bus1.Sym !== 2'b11) begin failures++; $display("FAIL basic_sym got=%b exp=11", bus1.Sym); end
        checks++; if (bus1.Owner !== 1'b0) begin failures++; $display("FAIL basic_owner got=%b exp=0", bus1.Owner); end
        bus1.Req = 2'b00;
        @(negedge Clk);
        checks++; if (bus1.Ack !== 2'b00) begin failures++; $display("FAIL basic_ack_pulse got=%b exp=00", bus1.Ack); end
        checks++; if (bus1.Sym !== 2'b11) begin failures++; $display("FAIL basic_sym_hold got=%b exp=11", bus1.Sym); end
    endtask

    task automatic test_round_robin();
        logic [15:0] esym [4];
        logic [1:0]  eack [4];
        logic [1:0]  a;
        int          cyc, last, k;
        bit          both_seen;
        esym = '{16'hFE5B, 16'hE41B, 16'h4036, 16'h03D4};
        eack = '{2'b01, 2'b10, 2'b01, 2'b10};
        cyc = 0; last = 0; k = 0; both_seen = 1'b0;
        do_reset();
        bus4.Req = 2'b11;
        while (k < 4 && cyc < 60) begin
            @(negedge Clk);
            cyc++;
            a = bus4.Ack;
            if (a == 2'b11) both_seen = 1'b1;
            if (a != 2'b00) begin
                checks++; if (a !== eack[k]) begin failures++; $display("FAIL rr_ack%0d got=%b exp=%b", k, a, eack[k]); end
                checks++; if (bus4.Sym !== esym[k]) begin failures++; $display("FAIL rr_sym%0d got=%h exp=%h", k, bus4.Sym, esym[k]); end
                checks++; if (bus4.Owner !== eack[k][1]) begin failures++; $display("FAIL rr_owner%0d got=%b exp=%b", k, bus4.Owner, eack[k][1]); end
                if (k > 0) begin
                    checks++; if (cyc - last != 6) begin failures++; $display("FAIL rr_spacing%0d got=%0d exp=6", k, cyc - last); end
                end
                last = cyc;
                k++;
            end
            bus4.Req = (k == 4) ? 2'b00 : ~a;
        end
        bus4.Req = 2'b00;
        checks++; if (k != 4) begin failures++; $display("FAIL rr_count got=%0d exp=4", k); end
        checks++; if (both_seen) begin failures++; $display("FAIL rr_ack_both got=11 exp=onehot"); end
    endtask

    task automatic test_no_starvation();
        int         c;
        logic [1:0] a;
        do_reset();
        bus4.Req = 2'b01;
        repeat (2) @(negedge Clk);
        bus4.Req = 2'b11;
        wait_ack4(20, c, a);
        checks++; if (a !== 2'b01) begin failures++; $display("FAIL starve_first got=%b exp=01", a); end
        checks++; if (bus4.Sym !== 16'hFE5B) begin failures++; $display("FAIL starve_sym0 got=%h exp=FE5B", bus4.Sym); end
        wait_ack4(20, c, a);
        checks++; if (a !== 2'b10) begin failures++; $display("FAIL starve_p1 got=%b exp=10", a); end
        checks++; if (c != 6) begin failures++; $display("FAIL starve_wait got=%0d exp=6", c); end
        checks++; if (bus4.Sym !== 16'hE41B) begin failures++; $display("FAIL starve_sym1 got=%h exp=E41B", bus4.Sym); end
        checks++; if (bus4.Owner !== 1'b1) begin failures++; $display("FAIL starve_owner got=%b exp=1", bus4.Owner); end
        bus4.Req = 2'b01;
        wait_ack4(20, c, a);
        checks++; if (a !== 2'b01) begin failures++; $display("FAIL starve_third got=%b exp=01", a); end
        checks++; if (bus4.Sym !== 16'h4036) begin failures++; $display("FAIL starve_sym2 got=%h exp=4036", bus4.Sym); end
        bus4.Req = 2'b00;
    endtask

    task automatic test_abort();
        int         c;
        logic [1:0] a;
        do_reset();
        // Early drop inside STEP is ignored.
        bus4.Req = 2'b01;
        @(posedge Clk);
        @(negedge Clk);
        @(negedge Clk);
        bus4.Req = 2'b00;
        checks++; if (bus4.Busy !== 1'b1) begin failures++; $display("FAIL abort_busy_step got=%b exp=1", bus4.Busy); end
        @(negedge Clk);
        bus4.Req = 2'b01;
        wait_ack4(10, c, a);
        checks++; if (a !== 2'b01) begin failures++; $display("FAIL early_drop_ack got=%b exp=01", a); end
        checks++; if (c != 3) begin failures++; $display("FAIL early_drop_lat got=%0d exp=3", c); end
        checks++; if (bus4.Sym !== 16'hFE5B) begin failures++; $display("FAIL early_drop_sym got=%h exp=FE5B", bus4.Sym); end
        bus4.Req = 2'b00;
        // Drop in the final STEP cycle aborts.
        @(negedge Clk);
        bus4.Req = 2'b01;
        @(posedge Clk);
        repeat (4) @(negedge Clk);
        bus4.Req = 2'b00;
        @(negedge Clk);
        checks++; if (bus4.Busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus4.Busy); end
        checks++; if (bus4.Ack !== 2'b00) begin failures++; $display("FAIL abort_ack_a got=%b exp=00", bus4.Ack); end
        @(negedge Clk);
        checks++; if (bus4.Ack !== 2'b00) begin failures++; $display("FAIL abort_ack_b got=%b exp=00", bus4.Ack); end
        checks++; if (bus4.Sym !== 16'hFE5B) begin failures++; $display("FAIL abort_sym_hold got=%h exp=FE5B", bus4.Sym); end
        checks++; if (dut4.u_lfsr.q !== 16'hE41B) begin failures++; $display("FAIL abort_lfsr got=%h exp=E41B", dut4.u_lfsr.q); end
        bus4.Req = 2'b01;
        wait_ack4(20, c, a);
        checks++; if (a !== 2'b01) begin failures++; $display("FAIL after_abort_ack got=%b exp=01", a); end
        checks++; if (bus4.Sym !== adv(16'hFE5B, 8)) begin failures++; $display("FAIL after_abort_sym got=%h exp=%h", bus4.Sym, adv(16'hFE5B, 8)); end
        bus4.Req = 2'b00;
    endtask

    task automatic test_reset_mid();
        int         c;
        logic [1:0] a;
        do_reset();
        bus4.Req = 2'b01;
        wait_ack4(20, c, a);
        checks++; if (a !== 2'b01) begin failures++; $display("FAIL rst_pre_ack got=%b exp=01", a); end
        #1 Rst = 1'b1;
        #1;
        checks++; if (bus4.Ack !== 2'b00) begin failures++; $display("FAIL rst_ack_clear got=%b exp=00", bus4.Ack); end
        checks++; if (bus4.Sym !== 16'h0000) begin failures++; $display("FAIL rst_sym_clear got=%h exp=0000", bus4.Sym); end
        @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #2 Rst = 1'b1;
        #1;
        checks++; if (bus4.Busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0", bus4.Busy); end
        checks++; if (bus4.Ack !== 2'b00) begin failures++; $display("FAIL rst_mid_ack got=%b exp=00", bus4.Ack); end
        checks++; if (dut4.u_lfsr.q !== 16'hFFFF) begin failures++; $display("FAIL rst_mid_lfsr got=%h exp=FFFF", dut4.u_lfsr.q); end
        @(negedge Clk);
        Rst = 1'b0;
        wait_ack4(20, c, a);
        checks++; if (a !== 2'b01) begin failures++; $display("FAIL rst_post_ack got=%b exp=01", a); end
        checks++; if (c != 6) begin failures++; $display("FAIL rst_post_lat got=%0d exp=6", c); end
        checks++; if (bus4.Sym !== 16'hFE5B) begin failures++; $display("FAIL rst_post_sym got=%h exp=FE5B", bus4.Sym); end
        bus4.Req = 2'b00;
    endtask

`ifdef LFSR_SEED_LOAD_EN
    task automatic test_seed_load();
        logic [15:0] run_a [8];
        logic [15:0] run_b [8];
        logic [15:0] s;
        logic [1:0]  a;
        do_reset();
        run_one(s, a);
        @(negedge Clk);
        SeedLoad = 1'b1;
        SeedIn   = 16'h0000;
        bus4.Req = 2'b01;
        @(negedge Clk);
        SeedLoad = 1'b0;
        bus4.Req = 2'b00;
        checks++; if (dut4.u_lfsr.q !== 16'hFFFF) begin failures++; $display("FAIL seed_zero got=%h exp=FFFF", dut4.u_lfsr.q); end
        checks++; if (bus4.Busy !== 1'b0) begin failures++; $display("FAIL seed_req_ignored got=%b exp=0", bus4.Busy); end
        for (int r = 0; r < 2; r++) begin
            @(negedge Clk);
            SeedLoad = 1'b1;
            SeedIn   = 16'h1234;
            @(negedge Clk);
            SeedLoad = 1'b0;
            for (int k = 0; k < 8; k++) begin
                run_one(s, a);
                if (r == 0) run_a[k] = s; else run_b[k] = s;
            end
        end
        for (int k = 0; k < 8; k++) begin
            checks++; if (run_a[k] !== adv(16'h1234, 4 * (k + 1))) begin failures++; $display("FAIL seed_model%0d got=%h exp=%h", k, run_a[k], adv(16'h1234, 4 * (k + 1))); end
            checks++; if (run_b[k] !== run_a[k]) begin failures++; $display("FAIL seed_replay%0d got=%h exp=%h", k, run_b[k], run_a[k]); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_steps1();
        test_round_robin();
        test_no_starvation();
        test_abort();
        test_reset_mid();
`ifdef LFSR_SEED_LOAD_EN
        test_seed_load();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_share_arbiter.md
Name: lfsr_share_arbiter

Overview:
- Shares one 16-bit Galois LFSR random source between the two players of the timed sequence-matching game.
- Each player requests a random symbol for the next sequence element.
- The block arbitrates round-robin, advances the LFSR a fixed number of steps per request to decorrelate consecutive symbols, and returns the symbol with a one-cycle acknowledge.
- Sits between the per-player game FSMs and the random source.

Parameters:
- SYM_W, 2, symbol width in bits; symbol = low SYM_W bits of LFSR state (1..16).
- STEPS, 4, LFSR advances per granted request (1..15).
- SEED, 16'hFFFF, reset/reload state; a value of 0 is replaced by 16'hFFFF.

Ports:
- Clk  in  1  clock, rising edge.
- Rst  in  1  reset, asynchronous, active-high.
- Req  in  2  per-player symbol request, level; bit i = player i.
- Ack  out  2  one-cycle pulse to the served player; one-hot or zero.
- Sym  out  SYM_W  delivered symbol; valid while Ack is high, held until the next delivery.
- Busy  out  1  high in every state except IDLE.
- Owner  out  1  index of the player currently granted or last served.

Behaviour:
- Rst asserted (async), all outputs zero:
  - Ack=0, Sym=0, Busy=0, Owner=0.
  - FSM=IDLE, LFSR=SEED, last-served pointer=1, so player 0 wins the first tie.
- LFSR (sub-module):
  - Polynomial x^16+x^5+x^3+x^2+1, Galois form, feedback = bit15.
  - next[0]=fb, next[2]=q[1]^fb, next[3]=q[2]^fb, next[5]=q[4]^fb; other bits shift up by one.
  - Advances only when step=1.
  - Lockup guard: if the state is ever 0, reload SEED on the next clock regardless of step.
- IDLE:
  - Req==0: stay.
  - One bit set: grant that player.
  - Both set: grant the player that is not the last-served pointer.
  - On grant: Owner<=winner, cnt<=STEPS, go STEP.
- STEP:
  - step=1 every cycle, cnt decrements.
  - When cnt==1, go DELIVER.
  - If Req[Owner] is low in the final STEP cycle, the request is aborted: go IDLE, no Ack, pointer unchanged. The LFSR has still advanced.
  - Req drops in earlier STEP cycles are ignored; only the final-cycle sample counts.
- DELIVER (exactly one cycle):
  - Ack[Owner]=1; Sym = LFSR[SYM_W-1:0] after the final step.
  - Pointer<=Owner, go IDLE.
- Latency: Req sampled in IDLE at edge t gives Ack high during the cycle after edge t+STEPS+1.
  - Minimum request-to-request spacing is STEPS+2 cycles.
- The non-owner's request waits in IDLE; it is granted next if still held, which guarantees no starvation.
- A requester must deassert Req in the Ack cycle. A Req still high in the following IDLE cycle is a new request.
- Reset mid-transaction: aborts immediately, no Ack, state as at reset.

Optional Feature:
- Macro: LFSR_SEED_LOAD_EN.
- Defined:
  - Adds ports SeedLoad (in, 1) and SeedIn (in, 16).
  - SeedLoad sampled high in IDLE loads SeedIn (0 maps to 16'hFFFF) and resets the pointer to 1. Same-cycle Req is ignored that cycle.
  - SeedLoad in other states is ignored.
  - Lets both players replay an identical sequence.
- Undefined: ports absent; the LFSR is loaded only by Rst and the lockup guard.

Decomposition:
- Shared package (lfsr_game_pkg):
  - LFSR width 16 and tap positions {2,3,5}.
  - Default seed 16'hFFFF.
  - FSM state enum: IDLE, STEP, DELIVER.
  - Player index type.
- One sub-module, lfsr16_step: enabled Galois LFSR with Clk, Rst (async high), step, load, load_val, q.

Test Plan:
- STEPS=1, SYM_W=2, SEED=FFFF, Req=01 held → Ack=01 two cycles after the grant edge; LFSR=16'hFFD3; Sym=2'b11; Owner=0.
- Both Req=11 from reset, each drops on its Ack → grants alternate 0,1,0,1; Ack never 11; each Ack exactly STEPS+2 cycles apart.
- Req[0] held continuously while Req[1] pulses once → player 1 is served within one transaction; no starvation.
- Req[0] deasserted in the final STEP cycle → no Ack, Busy falls; next request's Sym reflects LFSR advanced 2×STEPS from the prior state.
- Rst asserted mid-STEP (async, between edges) → Ack=0, Busy=0 immediately; after release the first delivery equals the reset-sequence value.
- With LFSR_SEED_LOAD_EN: SeedLoad with SeedIn=0 → LFSR=FFFF. Two runs of 8 requests after identical SeedIn values give identical Sym sequences.
